// File: rtl/matrix_transmitter_pkg.sv
// Shared codes for the matrix transmit path: command actions, parity modes,
// serial FSM state encoding and the number of cells each send action covers.
package matrix_transmitter_pkg;

    localparam logic [2:0] ACT_NOP  = 3'd0;
    localparam logic [2:0] ACT_WR   = 3'd1;
    localparam logic [2:0] ACT_CELL = 3'd2;
    localparam logic [2:0] ACT_ROW  = 3'd3;
    localparam logic [2:0] ACT_COL  = 3'd4;
    localparam logic [2:0] ACT_ALL  = 3'd5;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    function automatic logic [3:0] cells_for(input logic [2:0] act);
        case (act)
            ACT_CELL: cells_for = 4'd1;
            ACT_ROW:  cells_for = 4'd4;
            ACT_COL:  cells_for = 4'd2;
            ACT_ALL:  cells_for = 4'd8;
            default:  cells_for = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/tx_frame_serializer.sv
// One UART frame per load: start, 8 data bits LSB first, optional parity, stop; DIV clocks per bit.
// tx is registered and goes low the clock after load; frame_done flags the last clock of the stop bit.
module tx_frame_serializer
    import matrix_transmitter_pkg::*;
#(
    parameter int DIV = 3,
    parameter int PAR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       frame_done
);

    logic [2:0] state;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;
    logic       bit_end;

    assign bit_end    = (div_cnt == 8'(DIV - 1));
    assign frame_done = (state == ST_STOP) && bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else if (load) begin
            state   <= ST_START;
            div_cnt <= 8'd0;
            bit_cnt <= 3'd0;
            shreg   <= data;
            par_bit <= (PAR == PAR_ODD) ? ~^data : ^data;
            tx      <= 1'b0;
        end else if (state != ST_IDLE) begin
            div_cnt <= bit_end ? 8'd0 : div_cnt + 8'd1;
            if (bit_end) begin
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            if (PAR != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            // shreg[0] always holds the bit currently on the line
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/matrix_transmitter.sv
// 2x4 matrix of byte cells with host writes and row/column/all serial send commands.
// Commands are accepted only while idle; everything (writes included) is ignored while busy.
module matrix_transmitter
    import matrix_transmitter_pkg::*;
#(
    parameter int DIV = 3,
    parameter int PAR = 0,
    parameter int GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       row,
    input  logic [1:0] col,
    input  logic [2:0] action,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    logic [7:0] cells [8];
    logic [2:0] cmd_state;
    logic [2:0] cur_act;
    logic       cur_row;
    logic [1:0] cur_col;
    logic [3:0] cells_sent;
    logic [7:0] gap_cnt;

    logic       accept, send, more, gap_end, load, frame_done;
    logic       next_row;
    logic [1:0] next_col;
    logic [7:0] load_dat;

    assign accept  = start && !busy;
    assign send    = accept && (action >= ACT_CELL) && (action <= ACT_ALL);
    assign more    = (cells_sent + 4'd1) < cells_for(cur_act);
    assign gap_end = (cmd_state == ST_GAP) && (gap_cnt == 8'(GAP - 1));
    assign load    = send || gap_end || (frame_done && more && (GAP == 0));

    // cur_row/cur_col only advance at frame_done, so a back-to-back load must read the stepped cell
    assign load_dat = send       ? cells[{row, col}] :
                      frame_done ? cells[{next_row, next_col}] :
                                   cells[{cur_row, cur_col}];

    always_comb begin
        next_row = cur_row;
        next_col = cur_col;
        case (cur_act)
            ACT_ROW: next_col = cur_col + 2'd1;
            ACT_COL: next_row = ~cur_row;
            ACT_ALL: begin
                next_col = cur_col + 2'd1;
                if (cur_col == 2'd3)
                    next_row = ~cur_row;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_state  <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_act    <= ACT_NOP;
            cur_row    <= 1'b0;
            cur_col    <= 2'd0;
            cells_sent <= 4'd0;
            gap_cnt    <= 8'd0;
            for (int i = 0; i < 8; i++)
                cells[i] <= 8'd0;
        end else begin
            done <= 1'b0;
            if (accept && (action == ACT_WR))
                cells[{row, col}] <= din;
            if (send) begin
                cmd_state  <= ST_START;
                busy       <= 1'b1;
                cur_act    <= action;
                cur_row    <= row;
                cur_col    <= col;
                cells_sent <= 4'd0;
            end else begin
                case (cmd_state)
                    ST_START: begin
                        if (frame_done) begin
                            if (more) begin
                                cells_sent <= cells_sent + 4'd1;
                                cur_row    <= next_row;
                                cur_col    <= next_col;
                                if (GAP != 0) begin
                                    cmd_state <= ST_GAP;
                                    gap_cnt   <= 8'd0;
                                end
                            end else begin
                                cmd_state <= ST_IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_end)
                            cmd_state <= ST_START;
                        else
                            gap_cnt <= gap_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    tx_frame_serializer #(
        .DIV (DIV),
        .PAR (PAR)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (load_dat),
        .tx         (tx),
        .frame_done (frame_done)
    );

endmodule
